// File: rtl/serial_add_unit_if.sv
// Start/done handshake and result/flag bus of the bit-serial add/subtract unit.
// The master drives the operands; the slave returns the result and NZCV flags.
interface serial_add_unit_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, negative, zero, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, negative, zero, carry_out, overflow
  );
endinterface

// File: rtl/serial_add_unit.sv
// Bit-serial add/subtract unit: one full-adder slice, one bit per clock, LSB first.
// Produces a WIDTH-bit result with ARM NZCV flags behind a start/done handshake.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);
  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_unit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_unit_if.slave   bus
);
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-2:0] acc;
  logic             carry;
  logic             cin_msb;
  logic [CW-1:0]    count;

  logic             fa_sum;
  logic             fa_co;
  logic             load;
  logic             step;
  logic             last;
  logic             msb_cap;
  logic [WIDTH-1:0] acc_shift;

  fulladder u_fa (
    .a   (op_a[0]),
    .b   (op_b[0]),
    .ci  (carry),
    .sum (fa_sum),
    .co  (fa_co)
  );

  // Newest sum bit enters at the top; after the MSB step this is the full result.
  assign acc_shift = {fa_sum, acc};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath control decode
  always_comb begin
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    msb_cap = 1'b0;
    case (state)
      IDLE: load = bus.start;
      RUN: begin
        step    = 1'b1;
        last    = (count == CW'(WIDTH - 1));
        msb_cap = (count == CW'(WIDTH - 2));
      end
      DONE:    load = bus.start;
      default: ;
    endcase
  end

  // Operand shifters, carry chain and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      cin_msb <= 1'b0;
      count   <= '0;
    end else if (load) begin
      op_a  <= bus.a;
      op_b  <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub;
      count <= '0;
    end else if (step) begin
      acc   <= acc_shift[WIDTH-1:1];
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      carry <= fa_co;
      count <= count + CW'(1);
      if (msb_cap) cin_msb <= fa_co;
    end
  end

  // Handshake and result/flag registers; results only change on DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.negative  <= 1'b0;
      bus.zero      <= 1'b0;
      bus.carry_out <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      bus.busy <= (state_nxt == RUN);
      bus.done <= (state_nxt == DONE);
      if (last) begin
        bus.result    <= acc_shift;
        bus.negative  <= acc_shift[WIDTH-1];
        bus.zero      <= ~|acc_shift;
        bus.carry_out <= fa_co;
        bus.overflow  <= cin_msb ^ fa_co;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_unit.sv
// Directed bench for serial_add_unit: a 64-bit instance for arithmetic, flags and
// reset abort, and an 8-bit instance for the back-to-back handshake.
module tb_serial_add_unit;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  serial_add_unit_if #(.WIDTH(64)) b64 ();
  serial_add_unit_if #(.WIDTH(8))  b8 ();

  serial_add_unit #(.WIDTH(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));
  serial_add_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launches one 64-bit op and waits for done; lat counts edges from the start edge.
  task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic sub,
                       output int lat, output int busy_n, output logic ok);
    ok = 1'b0;
    lat = -1;
    busy_n = 0;
    @(negedge clk);
    b64.a = a;
    b64.b = b;
    b64.sub = sub;
    b64.start = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 1) begin
        b64.start = 1'b0;
        b64.a = 64'hDEAD_BEEF_0BAD_F00D;
        b64.b = 64'h0123_4567_89AB_CDEF;
        b64.sub = ~sub;
      end
      if (b64.busy) busy_n++;
      if (b64.done) begin
        ok = 1'b1;
        lat = i - 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (b64.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", b64.busy); end
    checks++; if (b64.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", b64.done); end
    checks++; if (b64.result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h want 0", b64.result); end
    checks++; if ({b64.negative, b64.zero, b64.carry_out, b64.overflow} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got NZCV=%b want 0000", {b64.negative, b64.zero, b64.carry_out, b64.overflow});
    end
    checks++; if ({b8.busy, b8.done, b8.result} !== 10'h0) begin
      errors++; $display("FAIL reset_dut8: got busy=%b done=%b result=%h want 0", b8.busy, b8.done, b8.result);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat, busy_n; logic ok;
    run64(64'd5, 64'd3, 1'b0, lat, busy_n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL add_timeout: no done within 200 cycles"); end
    checks++; if (lat !== 64) begin errors++; $display("FAIL add_latency: got %0d want 64", lat); end
    checks++; if (busy_n !== 64) begin errors++; $display("FAIL add_busy_cycles: got %0d want 64", busy_n); end
    checks++; if (b64.result !== 64'd8) begin errors++; $display("FAIL add_result: got %h want 8", b64.result); end
    checks++; if ({b64.negative, b64.zero, b64.carry_out, b64.overflow} !== 4'b0000) begin
      errors++; $display("FAIL add_flags: got NZCV=%b want 0000", {b64.negative, b64.zero, b64.carry_out, b64.overflow});
    end
    @(negedge clk);
    checks++; if (b64.done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b want 0", b64.done); end
    checks++; if (b64.result !== 64'd8) begin errors++; $display("FAIL add_result_hold: got %h want 8", b64.result); end
  endtask

  task automatic test_sub_zero();
    int lat, busy_n; logic ok;
    run64(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, lat, busy_n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL subz_timeout: no done within 200 cycles"); end
    checks++; if (b64.result !== 64'h0) begin errors++; $display("FAIL subz_result: got %h want 0", b64.result); end
    checks++; if ({b64.negative, b64.zero, b64.carry_out, b64.overflow} !== 4'b0110) begin
      errors++; $display("FAIL subz_flags: got NZCV=%b want 0110", {b64.negative, b64.zero, b64.carry_out, b64.overflow});
    end
  endtask

  task automatic test_overflow();
    int lat, busy_n; logic ok;
    run64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat, busy_n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout: no done within 200 cycles"); end
    checks++; if (b64.result !== 64'h8000_0000_0000_0000) begin
      errors++; $display("FAIL ovf_result: got %h want 8000000000000000", b64.result);
    end
    checks++; if ({b64.negative, b64.zero, b64.carry_out, b64.overflow} !== 4'b1001) begin
      errors++; $display("FAIL ovf_flags: got NZCV=%b want 1001", {b64.negative, b64.zero, b64.carry_out, b64.overflow});
    end
  endtask

  task automatic test_wrap();
    int lat, busy_n; logic ok;
    run64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat, busy_n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: no done within 200 cycles"); end
    checks++; if (b64.result !== 64'h0) begin errors++; $display("FAIL wrap_result: got %h want 0", b64.result); end
    checks++; if ({b64.negative, b64.zero, b64.carry_out, b64.overflow} !== 4'b0110) begin
      errors++; $display("FAIL wrap_flags: got NZCV=%b want 0110", {b64.negative, b64.zero, b64.carry_out, b64.overflow});
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, busy_n; logic ok; int stray;
    @(negedge clk);
    b64.a = 64'd5; b64.b = 64'd3; b64.sub = 1'b0; b64.start = 1'b1;
    @(negedge clk);
    b64.start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (b64.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", b64.busy); end
    rst_n = 1'b0;
    #1;
    checks++; if ({b64.busy, b64.done} !== 2'b00) begin
      errors++; $display("FAIL midrst_handshake: got busy=%b done=%b want 0 0", b64.busy, b64.done);
    end
    checks++; if (b64.result !== 64'h0) begin errors++; $display("FAIL midrst_result: got %h want 0", b64.result); end
    checks++; if ({b64.negative, b64.zero, b64.carry_out, b64.overflow} !== 4'b0000) begin
      errors++; $display("FAIL midrst_flags: got NZCV=%b want 0000", {b64.negative, b64.zero, b64.carry_out, b64.overflow});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (80) begin
      @(negedge clk);
      if (b64.busy || b64.done) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL midrst_idle: got %0d active cycles want 0", stray); end
    run64(64'd5, 64'd3, 1'b0, lat, busy_n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout: no done within 200 cycles"); end
    checks++; if (lat !== 64) begin errors++; $display("FAIL midrst_latency: got %0d want 64", lat); end
    checks++; if (b64.result !== 64'd8) begin errors++; $display("FAIL midrst_result_after: got %h want 8", b64.result); end
  endtask

  task automatic test_back_to_back();
    int n_done; int lat1, lat2; logic [7:0] res1, res2; logic [3:0] f1, f2; logic busy_at_done; int stray;
    n_done = 0; lat1 = -1; lat2 = -1; res1 = '0; res2 = '0; f1 = '0; f2 = '0; busy_at_done = 1'b0;
    @(negedge clk);
    b8.a = 8'h10; b8.b = 8'h20; b8.sub = 1'b1; b8.start = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) begin
        b8.a = 8'h01; b8.b = 8'h01; b8.sub = 1'b0;
      end
      if (b8.done) begin
        n_done++;
        busy_at_done = busy_at_done | b8.busy;
        if (n_done == 1) begin
          lat1 = i - 1; res1 = b8.result; f1 = {b8.negative, b8.zero, b8.carry_out, b8.overflow};
        end else begin
          lat2 = i - 1; res2 = b8.result; f2 = {b8.negative, b8.zero, b8.carry_out, b8.overflow};
          b8.start = 1'b0;
          break;
        end
      end
    end
    b8.start = 1'b0;
    checks++; if (n_done !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
    checks++; if (lat1 !== 8) begin errors++; $display("FAIL b2b_lat1: got %0d want 8", lat1); end
    checks++; if (res1 !== 8'hF0) begin errors++; $display("FAIL b2b_res1: got %h want f0", res1); end
    checks++; if (f1 !== 4'b1000) begin errors++; $display("FAIL b2b_flags1: got NZCV=%b want 1000", f1); end
    checks++; if (lat2 !== 17) begin errors++; $display("FAIL b2b_lat2: got %0d want 17", lat2); end
    checks++; if (res2 !== 8'h02) begin errors++; $display("FAIL b2b_res2: got %h want 02", res2); end
    checks++; if (f2 !== 4'b0000) begin errors++; $display("FAIL b2b_flags2: got NZCV=%b want 0000", f2); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL b2b_busy_in_done: got %b want 0", busy_at_done); end
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (b8.busy || b8.done) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL b2b_no_third_op: got %0d active cycles want 0", stray); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b1;
    b64.start = 1'b0; b64.sub = 1'b0; b64.a = '0; b64.b = '0;
    b8.start  = 1'b0; b8.sub  = 1'b0; b8.a  = '0; b8.b  = '0;
    test_reset();
    test_add();
    test_sub_zero();
    test_overflow();
    test_reset_mid_run();
    test_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_add_unit.md
# serial_add_unit

Bit-serial add/subtract unit built around a single `fulladder` instance, one bit per clock, LSB first. It is the sequential stage wrapped directly around the full-adder slice: it feeds `a`, `b` and `ci` each cycle and consumes `sum` and `co` into shift and carry registers. It produces a WIDTH-bit result plus ARM NZCV flags with a start/done handshake. It is the low-area alternative adder path for the ALU and multi-cycle datapath.

## Interface
- WIDTH, 64, operand/result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; accepted only in IDLE or DONE
- sub  input  1  0 = a + b, 1 = a − b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result and flags are newly valid
- result  output  WIDTH  registered sum/difference
- negative  output  1  result[WIDTH-1]
- zero  output  1  result == 0
- carry_out  output  1  final carry out of the MSB (ARM C: subtract gives 1 = no borrow)
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- One clock, asynchronous active-low reset.
- On reset assertion, regardless of state:
  - state → IDLE.
  - busy, done, result, negative, zero, carry_out, overflow → 0.
  - All internal shift, count and carry registers → 0.
- States are IDLE, RUN and DONE.
- IDLE, start=1:
  - Load opA ← a and opB ← (sub ? ~b : b).
  - Load carry ← sub and count ← 0.
  - Go to RUN.
- RUN, each cycle:
  - The fulladder sees a = opA[0], b = opB[0] and ci = carry.
  - At the edge: acc ← {sum, acc[WIDTH-1:1]}, opA >>= 1, opB >>= 1, carry ← co, count += 1.
  - When count == WIDTH-2 at the edge, also capture cin_msb ← co. This is the carry into bit WIDTH-1.
  - When count == WIDTH-1 at the edge, go to DONE.
- Entering DONE, at the same edge as the last bit:
  - result ← final acc, including the MSB sum bit being shifted in.
  - carry_out ← co.
  - overflow ← cin_msb ^ co.
  - negative and zero are derived from that same final value.
- DONE lasts exactly one cycle with done=1.
  - If start=1, load as in IDLE and go to RUN (back-to-back).
  - Otherwise go to IDLE.
- start in RUN is ignored. It is not queued.
- result and all flags hold their values until the next DONE entry or reset. They never change during RUN.
- Arithmetic is modulo 2^WIDTH and the carry beyond the MSB is dropped from result.
- sub = 1 with b = 0 gives carry_out = 1, the ARM convention.

## Timing
- Call the edge that accepts start E0.
- busy is high from after E0 through edge E(WIDTH). It is low in IDLE and DONE.
- Bit i of the result is computed between E(i) and E(i+1). Bit WIDTH-1 is captured at E(WIDTH).
- done is high for exactly the cycle between E(WIDTH) and E(WIDTH+1).
- Latency from start to done is WIDTH clocks, so 64 cycles at the default width.
- Maximum throughput is one operation per WIDTH+1 cycles when start is held high; the DONE cycle accepts the next start.
- The critical path is register → fulladder (2 gate delays, 100 ps) → register. The clock period must cover this plus setup.
- Reset asserted mid-RUN aborts the operation immediately (asynchronous). No done is produced and outputs read 0.
- The first start is sampled at the first rising edge after rst_n deasserts.

## Test plan
- Reset mid-RUN, WIDTH=64:
  - Stimulus: a=5, b=3, add; rst_n pulled low at cycle 10 of RUN.
  - Required: all outputs 0 immediately and state IDLE.
  - After release, a fresh a=5, b=3 add gives result=8 with correct timing.
- Add, WIDTH=64:
  - Stimulus: a=0x0000_0000_0000_0005, b=3, sub=0, start for 1 cycle.
  - Required: done exactly 64 cycles after the start edge, result=8, N=0, Z=0, C=0, V=0.
  - busy is high for exactly 64 cycles.
- Subtract to zero:
  - Stimulus: a=b=0x1234_5678_9ABC_DEF0, sub=1.
  - Required: result=0, Z=1, N=0, C=1, V=0.
- Signed overflow:
  - Stimulus: a=0x7FFF_FFFF_FFFF_FFFF, b=1, add.
  - Required: result=0x8000_0000_0000_0000, N=1, V=1, C=0.
- Unsigned wrap:
  - Stimulus: a=0xFFFF_FFFF_FFFF_FFFF, b=1, add.
  - Required: result=0, Z=1, C=1, V=0.
- Handshake and ignored start, WIDTH=8:
  - Stimulus: hold start=1 continuously; first op is 0x10 − 0x20, second op is 0x01 + 0x01.
  - Required: first done at cycle 8 with result=0xF0, N=1, C=0. The second op starts at the DONE edge and its done appears at cycle 17 with result=0x02.
  - Operand changes while busy have no effect on the op in flight.
